// File: rtl/toothless_pkg.sv
`default_nettype none
// ============================================================================
// Module      : toothless_pkg
// Description : Shared decode types, opcode constants and immediate helpers
//               for the RV32I decode stage.
// Revision    : 1.0  initial release
// ============================================================================
package toothless_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_XOR    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_AND    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_EQ     = 5'd10,
        ALU_NE     = 5'd11,
        ALU_LT     = 5'd12,
        ALU_GE     = 5'd13,
        ALU_LTU    = 5'd14,
        ALU_GEU    = 5'd15,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_opcode_e;

    localparam logic [6:0] OPC_LUI     = 7'h37;
    localparam logic [6:0] OPC_AUIPC   = 7'h17;
    localparam logic [6:0] OPC_JAL     = 7'h6F;
    localparam logic [6:0] OPC_JALR    = 7'h67;
    localparam logic [6:0] OPC_BRANCH  = 7'h63;
    localparam logic [6:0] OPC_LOAD    = 7'h03;
    localparam logic [6:0] OPC_STORE   = 7'h23;
    localparam logic [6:0] OPC_OP_IMM  = 7'h13;
    localparam logic [6:0] OPC_OP      = 7'h33;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;
    localparam logic [6:0] FUNCT7_MEXT = 7'h01;

    localparam logic [1:0] RF_WP_ALU   = 2'd0;
    localparam logic [1:0] RF_WP_LSU   = 2'd1;
    localparam logic [1:0] RF_WP_PC4   = 2'd2;

    localparam logic [1:0] OP_A_RS1    = 2'd0;
    localparam logic [1:0] OP_A_PC     = 2'd1;
    localparam logic [1:0] OP_A_ZERO   = 2'd2;

    localparam logic [1:0] OP_B_RS2    = 2'd0;
    localparam logic [1:0] OP_B_IMM    = 2'd1;

    localparam logic [1:0] CTRL_NONE   = 2'd0;
    localparam logic [1:0] CTRL_JUMP   = 2'd1;
    localparam logic [1:0] CTRL_BRANCH = 2'd2;

    localparam logic [1:0] DT_BYTE     = 2'd0;
    localparam logic [1:0] DT_HALF     = 2'd1;
    localparam logic [1:0] DT_WORD     = 2'd2;

    // Immediate is kept at 32 bits here; the stage widens it to DATA_WIDTH.
    typedef struct packed {
        alu_opcode_e alu_operator;
        logic [31:0] imm;
        logic        imm_valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_used;
        logic        rs2_used;
        logic        rd_used;
        logic [1:0]  rf_wp_mux_sel;
        logic [1:0]  alu_op_a_mux_sel;
        logic [1:0]  alu_op_b_mux_sel;
        logic [1:0]  ctrl_trans;
        logic        data_req;
        logic        data_we;
        logic        data_sign_ext;
        logic [1:0]  data_type;
        logic        illegal;
    } id_ex_t;

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage : toothless_pkg
`default_nettype wire

// File: rtl/rv32_decode_comb.sv
`default_nettype none
// ============================================================================
// Module      : rv32_decode_comb
// Description : Purely combinational RV32I instruction decoder.
//               Define DECODE_MEXT_EN to decode the M-extension encodings.
// Revision    : 1.0  initial release
// ============================================================================
module rv32_decode_comb
    import toothless_pkg::*;
(
    input  logic [31:0] i_instr,
    output id_ex_t      o_dec
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_illegal;
    id_ex_t     w_dec;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    always_comb begin
        w_dec              = '0;
        w_illegal          = 1'b0;
        w_dec.alu_operator = ALU_ADD;
        w_dec.rs1          = i_instr[19:15];
        w_dec.rs2          = i_instr[24:20];
        w_dec.rd           = i_instr[11:7];

        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_dec.imm              = imm_u(i_instr);
                w_dec.imm_valid        = 1'b1;
                w_dec.rd_used          = 1'b1;
                w_dec.alu_op_a_mux_sel = (w_opcode == OPC_LUI) ? OP_A_ZERO : OP_A_PC;
                w_dec.alu_op_b_mux_sel = OP_B_IMM;
            end
            OPC_JAL: begin
                w_dec.imm              = imm_j(i_instr);
                w_dec.imm_valid        = 1'b1;
                w_dec.rd_used          = 1'b1;
                w_dec.rf_wp_mux_sel    = RF_WP_PC4;
                w_dec.alu_op_a_mux_sel = OP_A_PC;
                w_dec.alu_op_b_mux_sel = OP_B_IMM;
                w_dec.ctrl_trans       = CTRL_JUMP;
            end
            OPC_JALR: begin
                w_dec.imm              = imm_i(i_instr);
                w_dec.imm_valid        = 1'b1;
                w_dec.rs1_used         = 1'b1;
                w_dec.rd_used          = 1'b1;
                w_dec.rf_wp_mux_sel    = RF_WP_PC4;
                w_dec.alu_op_b_mux_sel = OP_B_IMM;
                w_dec.ctrl_trans       = CTRL_JUMP;
                w_illegal              = (w_funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_dec.imm        = imm_b(i_instr);
                w_dec.imm_valid  = 1'b1;
                w_dec.rs1_used   = 1'b1;
                w_dec.rs2_used   = 1'b1;
                w_dec.ctrl_trans = CTRL_BRANCH;
                case (w_funct3)
                    3'b000:  w_dec.alu_operator = ALU_EQ;
                    3'b001:  w_dec.alu_operator = ALU_NE;
                    3'b100:  w_dec.alu_operator = ALU_LT;
                    3'b101:  w_dec.alu_operator = ALU_GE;
                    3'b110:  w_dec.alu_operator = ALU_LTU;
                    3'b111:  w_dec.alu_operator = ALU_GEU;
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                w_dec.imm              = imm_i(i_instr);
                w_dec.imm_valid        = 1'b1;
                w_dec.rs1_used         = 1'b1;
                w_dec.rd_used          = 1'b1;
                w_dec.rf_wp_mux_sel    = RF_WP_LSU;
                w_dec.alu_op_b_mux_sel = OP_B_IMM;
                w_dec.data_req         = 1'b1;
                w_dec.data_sign_ext    = !w_funct3[2];
                w_dec.data_type        = w_funct3[1:0];
                // Only byte and half have unsigned variants; size 11 is reserved.
                w_illegal = (w_funct3[1:0] == 2'b11) || (w_funct3[2] && w_funct3[1]);
            end
            OPC_STORE: begin
                w_dec.imm              = imm_s(i_instr);
                w_dec.imm_valid        = 1'b1;
                w_dec.rs1_used         = 1'b1;
                w_dec.rs2_used         = 1'b1;
                w_dec.alu_op_b_mux_sel = OP_B_IMM;
                w_dec.data_req         = 1'b1;
                w_dec.data_we          = 1'b1;
                w_dec.data_type        = w_funct3[1:0];
                w_illegal              = (w_funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                w_dec.imm              = imm_i(i_instr);
                w_dec.imm_valid        = 1'b1;
                w_dec.rs1_used         = 1'b1;
                w_dec.rd_used          = 1'b1;
                w_dec.alu_op_b_mux_sel = OP_B_IMM;
                case (w_funct3)
                    3'b000: w_dec.alu_operator = ALU_ADD;
                    3'b010: w_dec.alu_operator = ALU_SLT;
                    3'b011: w_dec.alu_operator = ALU_SLTU;
                    3'b100: w_dec.alu_operator = ALU_XOR;
                    3'b110: w_dec.alu_operator = ALU_OR;
                    3'b111: w_dec.alu_operator = ALU_AND;
                    3'b001: begin
                        w_dec.alu_operator = ALU_SLL;
                        w_dec.imm          = {27'b0, i_instr[24:20]};
                        w_illegal          = (w_funct7 != FUNCT7_BASE);
                    end
                    default: begin
                        w_dec.imm = {27'b0, i_instr[24:20]};
                        if (w_funct7 == FUNCT7_BASE) begin
                            w_dec.alu_operator = ALU_SRL;
                        end else if (w_funct7 == FUNCT7_ALT) begin
                            w_dec.alu_operator = ALU_SRA;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                endcase
            end
            OPC_OP: begin
                w_dec.rs1_used = 1'b1;
                w_dec.rs2_used = 1'b1;
                w_dec.rd_used  = 1'b1;
                case (w_funct7)
                    FUNCT7_BASE: begin
                        case (w_funct3)
                            3'b000: w_dec.alu_operator = ALU_ADD;
                            3'b001: w_dec.alu_operator = ALU_SLL;
                            3'b010: w_dec.alu_operator = ALU_SLT;
                            3'b011: w_dec.alu_operator = ALU_SLTU;
                            3'b100: w_dec.alu_operator = ALU_XOR;
                            3'b101: w_dec.alu_operator = ALU_SRL;
                            3'b110: w_dec.alu_operator = ALU_OR;
                            3'b111: w_dec.alu_operator = ALU_AND;
                        endcase
                    end
                    FUNCT7_ALT: begin
                        if (w_funct3 == 3'b000) begin
                            w_dec.alu_operator = ALU_SUB;
                        end else if (w_funct3 == 3'b101) begin
                            w_dec.alu_operator = ALU_SRA;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
`ifdef DECODE_MEXT_EN
                    FUNCT7_MEXT: begin
                        case (w_funct3)
                            3'b000: w_dec.alu_operator = ALU_MUL;
                            3'b001: w_dec.alu_operator = ALU_MULH;
                            3'b010: w_dec.alu_operator = ALU_MULHSU;
                            3'b011: w_dec.alu_operator = ALU_MULHU;
                            3'b100: w_dec.alu_operator = ALU_DIV;
                            3'b101: w_dec.alu_operator = ALU_DIVU;
                            3'b110: w_dec.alu_operator = ALU_REM;
                            3'b111: w_dec.alu_operator = ALU_REMU;
                        endcase
                    end
`endif
                    default: w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase

        // An illegal word must not write back, touch memory or redirect fetch.
        if (w_illegal) begin
            w_dec.rd_used    = 1'b0;
            w_dec.data_req   = 1'b0;
            w_dec.data_we    = 1'b0;
            w_dec.ctrl_trans = CTRL_NONE;
        end
        if (w_dec.rd == 5'd0) begin
            w_dec.rd_used = 1'b0;
        end
        w_dec.illegal = w_illegal;
    end

    assign o_dec = w_dec;

endmodule : rv32_decode_comb
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered RV32I decode stage with load-use interlock, flush
//               and saturating stall counter. DECODE_MEXT_EN adds M decode.
// Revision    : 1.0  initial release
// ============================================================================
module decode_stage
    import toothless_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 16,
    parameter int HAZARD_CHECK = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           instr_i,
    input  logic [PC_WIDTH-1:0]   pc_i,
    input  logic                  ex_load_valid_i,
    input  logic [4:0]            ex_load_rd_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [PC_WIDTH-1:0]   out_pc_o,
    output alu_opcode_e           out_alu_operator_o,
    output logic [DATA_WIDTH-1:0] out_imm_o,
    output logic                  out_imm_valid_o,
    output logic [4:0]            out_rs1_o,
    output logic [4:0]            out_rs2_o,
    output logic [4:0]            out_rd_o,
    output logic                  out_rs1_used_o,
    output logic                  out_rs2_used_o,
    output logic                  out_rd_used_o,
    output logic [1:0]            out_rf_wp_mux_sel_o,
    output logic [1:0]            out_alu_op_a_mux_sel_o,
    output logic [1:0]            out_alu_op_b_mux_sel_o,
    output logic [1:0]            out_ctrl_trans_o,
    output logic                  out_data_req_o,
    output logic                  out_data_we_o,
    output logic                  out_data_sign_ext_o,
    output logic [1:0]            out_data_type_o,
    output logic                  out_illegal_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    id_ex_t                w_dec;
    id_ex_t                r_bundle;
    logic [PC_WIDTH-1:0]   r_pc;
    logic                  r_valid;
    logic                  w_hazard;
    logic                  w_accept;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;

    rv32_decode_comb u_decode (
        .i_instr (instr_i),
        .o_dec   (w_dec)
    );

    generate
        if (HAZARD_CHECK != 0) begin : g_hazard
            assign w_hazard = ex_load_valid_i && (ex_load_rd_i != 5'd0) &&
                              ((w_dec.rs1_used && (w_dec.rs1 == ex_load_rd_i)) ||
                               (w_dec.rs2_used && (w_dec.rs2 == ex_load_rd_i)));
        end else begin : g_no_hazard
            assign w_hazard = 1'b0;
        end
    endgenerate

    assign in_ready_o = !flush_i && !w_hazard && (!r_valid || out_ready_i);
    assign w_accept   = in_valid_i && in_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_bundle <= '0;
            r_pc     <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_bundle <= w_dec;
            r_pc     <= pc_i;
        end else if (r_valid && out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // A flush overrides the interlock, so that cycle is not a lost stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (in_valid_i && w_hazard && !flush_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid_o            = r_valid;
    assign out_pc_o               = r_pc;
    assign out_alu_operator_o     = r_bundle.alu_operator;
    assign out_imm_o              = DATA_WIDTH'($signed(r_bundle.imm));
    assign out_imm_valid_o        = r_bundle.imm_valid;
    assign out_rs1_o              = r_bundle.rs1;
    assign out_rs2_o              = r_bundle.rs2;
    assign out_rd_o               = r_bundle.rd;
    assign out_rs1_used_o         = r_bundle.rs1_used;
    assign out_rs2_used_o         = r_bundle.rs2_used;
    assign out_rd_used_o          = r_bundle.rd_used;
    assign out_rf_wp_mux_sel_o    = r_bundle.rf_wp_mux_sel;
    assign out_alu_op_a_mux_sel_o = r_bundle.alu_op_a_mux_sel;
    assign out_alu_op_b_mux_sel_o = r_bundle.alu_op_b_mux_sel;
    assign out_ctrl_trans_o       = r_bundle.ctrl_trans;
    assign out_data_req_o         = r_bundle.data_req;
    assign out_data_we_o          = r_bundle.data_we;
    assign out_data_sign_ext_o    = r_bundle.data_sign_ext;
    assign out_data_type_o        = r_bundle.data_type;
    assign out_illegal_o          = r_bundle.illegal;
    assign stall_cnt_o            = r_stall_cnt;

endmodule : decode_stage
`default_nettype wire
